// File: rtl/result_checker.sv
// ---------------------------------------------------------------------------
// result_checker
//
// End-of-test result checker on the cpu_clk domain. After arming it waits for
// the end-of-program marker (or an optional timeout). It then reads a memory
// region one word at a time and compares each word against a synchronous
// golden ROM. When the walk is finished it reports pass/fail, the number of
// mismatches and the index of the first mismatch.
//
// Ports
//   cpu_clk, cpu_rst    clock, synchronous active-high reset
//   start               1-cycle arm pulse (accepted only in IDLE or DONE)
//   num_words           number of words to compare, sampled on start
//   tmo_cycles          timeout limit in cycles, sampled on start (0 = none)
//   end_word            live value of the end-marker location
//   mem_req/mem_addr    read request, held with a stable address until mem_ready
//   mem_ready           request accepted this cycle
//   mem_rvalid/rdata    read response, one pulse per accepted request
//   gold_idx            golden ROM index (ROM has 1-cycle latency)
//   gold_rdata          golden data for the previous cycle's gold_idx
//   busy                checker is waiting or scanning
//   done                level, high in DONE until the next start or reset
//   pass                valid with done: no mismatches and no timeout
//   timeout             timeout occurred (sticky until start/reset)
//   err_cnt             mismatch count, saturating at all-ones
//   first_err_idx       index of the first mismatch, all-ones if none
// ---------------------------------------------------------------------------
module result_checker #(
    parameter int unsigned       ADDR_W     = 32,
    parameter int unsigned       DATA_W     = 32,
    parameter int unsigned       CNT_W      = 13,
    parameter logic [ADDR_W-1:0] TEST_START = 'h40000,
    parameter logic [ADDR_W-1:0] ADDR_STEP  = 1,
    parameter logic [DATA_W-1:0] END_CODE   = {DATA_W{1'b1}},
    parameter int unsigned       TMO_W      = 32
) (
    input  logic              cpu_clk,
    input  logic              cpu_rst,
    input  logic              start,
    input  logic [CNT_W-1:0]  num_words,
    input  logic [TMO_W-1:0]  tmo_cycles,
    input  logic [DATA_W-1:0] end_word,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ready,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [CNT_W-1:0]  gold_idx,
    input  logic [DATA_W-1:0] gold_rdata,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic              timeout,
    output logic [CNT_W-1:0]  err_cnt,
    output logic [CNT_W-1:0]  first_err_idx
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_END,
        S_SCAN_REQ,
        S_SCAN_WAIT,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  num_words_q, num_words_d;
    logic [TMO_W-1:0]  tmo_cycles_q, tmo_cycles_d;
    logic [TMO_W-1:0]  tmo_cnt_q, tmo_cnt_d;
    logic [CNT_W-1:0]  idx_q, idx_d;
    logic [CNT_W-1:0]  err_cnt_q, err_cnt_d;
    logic [CNT_W-1:0]  first_err_idx_q, first_err_idx_d;
    logic              timeout_q, timeout_d;
    logic              done_q, done_d;
    logic              pass_q, pass_d;
    logic              busy_q, busy_d;
    logic              mem_req_q, mem_req_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [CNT_W-1:0]  gold_idx_q, gold_idx_d;

    // Decode helpers, all defaulted at the top of the combinational block.
    logic              end_hit;
    logic              tmo_hit;
    logic              word_mismatch;
    logic [CNT_W-1:0]  idx_inc;
    logic              go_scan;
    logic              go_done;
    logic [ADDR_W-1:0] next_addr;

    always_comb begin
        state_d         = state_q;
        num_words_d     = num_words_q;
        tmo_cycles_d    = tmo_cycles_q;
        tmo_cnt_d       = tmo_cnt_q;
        idx_d           = idx_q;
        err_cnt_d       = err_cnt_q;
        first_err_idx_d = first_err_idx_q;
        timeout_d       = timeout_q;
        done_d          = done_q;
        pass_d          = pass_q;
        busy_d          = busy_q;
        mem_req_d       = mem_req_q;
        mem_addr_d      = mem_addr_q;
        gold_idx_d      = gold_idx_q;

        end_hit         = 1'b0;
        tmo_hit         = 1'b0;
        word_mismatch   = 1'b0;
        idx_inc         = idx_q + 1'b1;
        go_scan         = 1'b0;
        go_done         = 1'b0;
        next_addr       = mem_addr_q;

        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d         = S_WAIT_END;
                    num_words_d     = num_words;
                    tmo_cycles_d    = tmo_cycles;
                    tmo_cnt_d       = '0;
                    idx_d           = '0;
                    err_cnt_d       = '0;
                    first_err_idx_d = '1;
                    timeout_d       = 1'b0;
                    done_d          = 1'b0;
                    pass_d          = 1'b0;
                    busy_d          = 1'b1;
                end
            end

            S_WAIT_END: begin
                tmo_cnt_d = tmo_cnt_q + 1'b1;
                end_hit   = (end_word == END_CODE);
                tmo_hit   = (tmo_cycles_q != '0) &&
                            (tmo_cnt_q == tmo_cycles_q - 1'b1);
                if (end_hit || tmo_hit) begin
                    // A marker seen on the limit cycle counts as a clean end.
                    if (!end_hit) begin
                        timeout_d = 1'b1;
                    end
                    if (num_words_q == '0) begin
                        go_done = 1'b1;
                    end else begin
                        go_scan   = 1'b1;
                        idx_d     = '0;
                        next_addr = TEST_START;
                    end
                end
            end

            S_SCAN_REQ: begin
                if (mem_ready) begin
                    mem_req_d = 1'b0;
                    state_d   = S_SCAN_WAIT;
                end
            end

            S_SCAN_WAIT: begin
                if (mem_rvalid) begin
                    // gold_idx has been stable since SCAN_REQ entry, so the
                    // ROM output already belongs to this word.
                    word_mismatch = (mem_rdata != gold_rdata);
                    if (word_mismatch) begin
                        if (err_cnt_q != '1) begin
                            err_cnt_d = err_cnt_q + 1'b1;
                        end
                        if (first_err_idx_q == '1) begin
                            first_err_idx_d = idx_q;
                        end
                    end
                    idx_d = idx_inc;
                    if (idx_inc == num_words_q) begin
                        go_done = 1'b1;
                    end else begin
                        // Running sum equals TEST_START + idx*ADDR_STEP
                        // modulo 2^ADDR_W without a multiplier.
                        go_scan   = 1'b1;
                        next_addr = mem_addr_q + ADDR_STEP;
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (go_scan) begin
            state_d    = S_SCAN_REQ;
            mem_req_d  = 1'b1;
            mem_addr_d = next_addr;
            gold_idx_d = idx_d;
        end

        if (go_done) begin
            state_d = S_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            // Uses the updated error count so the last word is included.
            pass_d  = (err_cnt_d == '0) && !timeout_d;
        end
    end

    always_ff @(posedge cpu_clk) begin
        if (cpu_rst) begin
            state_q         <= S_IDLE;
            num_words_q     <= '0;
            tmo_cycles_q    <= '0;
            tmo_cnt_q       <= '0;
            idx_q           <= '0;
            err_cnt_q       <= '0;
            first_err_idx_q <= '1;
            timeout_q       <= 1'b0;
            done_q          <= 1'b0;
            pass_q          <= 1'b0;
            busy_q          <= 1'b0;
            mem_req_q       <= 1'b0;
            mem_addr_q      <= '0;
            gold_idx_q      <= '0;
        end else begin
            state_q         <= state_d;
            num_words_q     <= num_words_d;
            tmo_cycles_q    <= tmo_cycles_d;
            tmo_cnt_q       <= tmo_cnt_d;
            idx_q           <= idx_d;
            err_cnt_q       <= err_cnt_d;
            first_err_idx_q <= first_err_idx_d;
            timeout_q       <= timeout_d;
            done_q          <= done_d;
            pass_q          <= pass_d;
            busy_q          <= busy_d;
            mem_req_q       <= mem_req_d;
            mem_addr_q      <= mem_addr_d;
            gold_idx_q      <= gold_idx_d;
        end
    end

    assign mem_req       = mem_req_q;
    assign mem_addr      = mem_addr_q;
    assign gold_idx      = gold_idx_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign pass          = pass_q;
    assign timeout       = timeout_q;
    assign err_cnt       = err_cnt_q;
    assign first_err_idx = first_err_idx_q;

endmodule

// File: tb/tb_result_checker.sv
// ---------------------------------------------------------------------------
// tb_result_checker
//
// Directed bench for result_checker. A small memory responder (ready two
// cycles after a request is seen, rvalid three cycles after ready) and a
// one-cycle-latency golden ROM surround the checker. Expected values are
// written by hand next to each step.
// ---------------------------------------------------------------------------
module tb_result_checker;

    localparam logic [31:0] TEST_START = 32'h0004_0000;
    localparam logic [12:0] ALL1       = 13'h1FFF;

    logic        cpu_clk = 1'b0;
    logic        cpu_rst;
    logic        start;
    logic [12:0] num_words;
    logic [31:0] tmo_cycles;
    logic [31:0] end_word;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ready;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic [12:0] gold_idx;
    logic [31:0] gold_rdata;
    logic        busy;
    logic        done;
    logic        pass;
    logic        timeout;
    logic [12:0] err_cnt;
    logic [12:0] first_err_idx;

    logic [31:0] mem_arr  [8];
    logic [31:0] gold_arr [8];
    logic [31:0] addr_log [$];
    int          req_cycles = 0;

    int n_pass  = 0;
    int n_total = 0;

    result_checker dut (
        .cpu_clk       (cpu_clk),
        .cpu_rst       (cpu_rst),
        .start         (start),
        .num_words     (num_words),
        .tmo_cycles    (tmo_cycles),
        .end_word      (end_word),
        .mem_req       (mem_req),
        .mem_addr      (mem_addr),
        .mem_ready     (mem_ready),
        .mem_rvalid    (mem_rvalid),
        .mem_rdata     (mem_rdata),
        .gold_idx      (gold_idx),
        .gold_rdata    (gold_rdata),
        .busy          (busy),
        .done          (done),
        .pass          (pass),
        .timeout       (timeout),
        .err_cnt       (err_cnt),
        .first_err_idx (first_err_idx)
    );

    always #5 cpu_clk = ~cpu_clk;

    // Synchronous golden ROM, one cycle of latency.
    always @(posedge cpu_clk) gold_rdata <= gold_arr[gold_idx[2:0]];

    always @(posedge cpu_clk) if (mem_req === 1'b1) req_cycles <= req_cycles + 1;

    // Memory responder.
    initial begin : responder
        logic [31:0] a;
        logic [31:0] off;
        mem_ready  = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        forever begin
            @(negedge cpu_clk);
            if (mem_req === 1'b1) begin
                repeat (2) @(negedge cpu_clk);
                mem_ready = 1'b1;
                a = mem_addr;
                addr_log.push_back(a);
                @(negedge cpu_clk);
                mem_ready = 1'b0;
                repeat (2) @(negedge cpu_clk);
                off = a - TEST_START;
                mem_rdata  = (off < 32'd8) ? mem_arr[off[2:0]] : 32'hDEAD_BEEF;
                mem_rvalid = 1'b1;
                @(negedge cpu_clk);
                mem_rvalid = 1'b0;
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge cpu_clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int cyc);
        cyc = 0;
        while (done !== 1'b1 && cyc < budget) begin
            @(negedge cpu_clk);
            cyc++;
        end
    endtask

    task automatic wait_req(input int budget, output int cyc);
        cyc = 0;
        while (mem_req !== 1'b1 && cyc < budget) begin
            @(negedge cpu_clk);
            cyc++;
        end
    endtask

    initial begin : main
        int cyc;
        int lb;
        int base;
        int k;

        for (int i = 0; i < 8; i++) begin
            gold_arr[i] = 32'h1000_0000 + i * 32'h0101_0101;
            mem_arr[i]  = gold_arr[i];
        end
        cpu_rst    = 1'b1;
        start      = 1'b0;
        num_words  = '0;
        tmo_cycles = '0;
        end_word   = '0;

        // 1: reset
        repeat (3) @(negedge cpu_clk);
        check("rst_mem_req", mem_req, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_pass", pass, 0);
        check("rst_timeout", timeout, 0);
        check("rst_err_cnt", err_cnt, 0);
        check("rst_first_err", first_err_idx, ALL1);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_gold_idx", gold_idx, 0);
        cpu_rst = 1'b0;
        @(negedge cpu_clk);
        check("idle_busy", busy, 0);

        // 2: all words match
        num_words = 13'd4;
        lb = addr_log.size();
        pulse_start();
        check("t2_busy", busy, 1);
        repeat (9) @(negedge cpu_clk);
        check("t2_no_req_before_end", mem_req, 0);
        end_word = 32'hFFFF_FFFF;
        wait_done(200, cyc);
        check("t2_done_in_time", done, 1);
        check("t2_pass", pass, 1);
        check("t2_err_cnt", err_cnt, 0);
        check("t2_first_err", first_err_idx, ALL1);
        check("t2_timeout", timeout, 0);
        check("t2_busy_low", busy, 0);
        check("t2_n_reads", addr_log.size() - lb, 4);
        for (int i = 0; i < 4; i++)
            check($sformatf("t2_addr%0d", i), addr_log[lb + i], TEST_START + i);
        end_word = '0;

        // 3: words 1 and 3 corrupted
        mem_arr[1] = mem_arr[1] ^ 32'h0000_0001;
        mem_arr[3] = mem_arr[3] ^ 32'h0000_00FF;
        pulse_start();
        check("t3_done_cleared", done, 0);
        repeat (9) @(negedge cpu_clk);
        end_word = 32'hFFFF_FFFF;
        wait_done(200, cyc);
        check("t3_done_in_time", done, 1);
        check("t3_err_cnt", err_cnt, 2);
        check("t3_first_err", first_err_idx, 1);
        check("t3_pass", pass, 0);
        end_word   = '0;
        mem_arr[1] = gold_arr[1];
        mem_arr[3] = gold_arr[3];

        // 4: timeout after 50 cycles, both words still scanned
        tmo_cycles = 32'd50;
        num_words  = 13'd2;
        lb = addr_log.size();
        pulse_start();
        k = 0;
        while (timeout !== 1'b1 && k < 200) begin
            @(negedge cpu_clk);
            k++;
        end
        check("t4_timeout_cycle", k, 50);
        check("t4_req_after_tmo", mem_req, 1);
        wait_done(200, cyc);
        check("t4_done_in_time", done, 1);
        check("t4_timeout", timeout, 1);
        check("t4_err_cnt", err_cnt, 0);
        check("t4_pass", pass, 0);
        check("t4_n_reads", addr_log.size() - lb, 2);

        // 5a: end marker on the exact timeout cycle
        tmo_cycles = 32'd5;
        num_words  = 13'd1;
        pulse_start();
        check("t5_timeout_cleared", timeout, 0);
        k = 0;
        while (k < 4) begin
            @(negedge cpu_clk);
            k++;
        end
        end_word = 32'hFFFF_FFFF;
        @(negedge cpu_clk);
        check("t5_tie_timeout", timeout, 0);
        check("t5_tie_req", mem_req, 1);
        wait_done(200, cyc);
        check("t5_tie_done", done, 1);
        check("t5_tie_pass", pass, 1);

        // 5b: zero words
        tmo_cycles = '0;
        num_words  = '0;
        base = req_cycles;
        pulse_start();
        wait_done(50, cyc);
        check("t5_zero_done", done, 1);
        check("t5_zero_pass", pass, 1);
        check("t5_zero_no_req", req_cycles - base, 0);
        check("t5_zero_err", err_cnt, 0);

        // 6a: start pulses while busy are ignored
        end_word  = '0;
        num_words = 13'd3;
        lb = addr_log.size();
        pulse_start();
        repeat (3) @(negedge cpu_clk);
        num_words = 13'd5;
        pulse_start();
        end_word = 32'hFFFF_FFFF;
        wait_req(50, cyc);
        check("t6_req_seen", mem_req, 1);
        pulse_start();
        wait_done(200, cyc);
        check("t6_done", done, 1);
        check("t6_pass", pass, 1);
        check("t6_n_reads", addr_log.size() - lb, 3);
        if (addr_log.size() - lb >= 3)
            for (int i = 0; i < 3; i++)
                check($sformatf("t6_addr%0d", i), addr_log[lb + i], TEST_START + i);

        // 6b: reset while mem_req is high, late rvalid must be ignored
        mem_arr[0] = 32'h0BAD_0BAD;
        num_words  = 13'd3;
        pulse_start();
        wait_req(50, cyc);
        check("t6_req_before_rst", mem_req, 1);
        cpu_rst = 1'b1;
        @(negedge cpu_clk);
        check("t6_rst_req", mem_req, 0);
        check("t6_rst_busy", busy, 0);
        check("t6_rst_done", done, 0);
        cpu_rst = 1'b0;
        repeat (10) @(negedge cpu_clk);
        check("t6_late_err", err_cnt, 0);
        check("t6_late_first", first_err_idx, ALL1);
        check("t6_late_busy", busy, 0);
        check("t6_late_req", mem_req, 0);
        check("t6_late_done", done, 0);
        mem_arr[0] = gold_arr[0];

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
